freq_period_monitor: RTL

FREQ_PERIOD_MONITOR -- requirements
Module: freq_period_monitor

---
 rtl/freq_period_monitor.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/freq_period_monitor.sv
// freq_period_monitor: measures the period and high time of a square wave,
// averages both over a sliding window, and reports frequency stability and
// loss of input.
module freq_period_monitor #(
  parameter int COUNTER_WIDTH = 18,
  parameter int AVG_LOG2      = 2,
  parameter int THRESH_SHIFT  = 5,
  parameter int STABLE_CYCLES = 4,
  parameter int DEBOUNCE      = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     signal_in,
  input  logic                     enable,
  output logic [COUNTER_WIDTH-1:0] period,
  output logic [COUNTER_WIDTH-1:0] high_time,
  output logic                     period_valid,
  output logic                     stable,
  output logic                     timeout
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = COUNTER_WIDTH + AVG_LOG2;
  localparam int FW    = AVG_LOG2 + 1;
  localparam int DBW   = $clog2(DEBOUNCE + 1);
  localparam int SCW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  logic                     filt;
  logic [DBW-1:0]           db_cnt;
  logic                     rise;
  logic                     fall;

  logic [COUNTER_WIDTH-1:0] cnt;
  logic                     armed;
  logic [COUNTER_WIDTH-1:0] h_cap;
  logic [COUNTER_WIDTH-1:0] win_p [DEPTH];
  logic [COUNTER_WIDTH-1:0] win_h [DEPTH];
  logic [AVG_LOG2-1:0]      wr_ptr;
  logic [FW-1:0]            fill;
  logic [SW-1:0]            sum_p;
  logic [SW-1:0]            sum_h;
  logic [SCW-1:0]           stable_cnt;
  logic [COUNTER_WIDTH-1:0] avg_p;
  logic [COUNTER_WIDTH-1:0] thresh;
  logic                     upd;

  logic                     full;
  logic                     push;
  logic                     at_target;
  logic                     in_range;
  logic [COUNTER_WIDTH-1:0] oldest_p;
  logic [COUNTER_WIDTH-1:0] oldest_h;
  logic [COUNTER_WIDTH-1:0] lo_bound;
  logic [COUNTER_WIDTH:0]   hi_bound;

  // The oldest window entry only leaves the sum once the window is full.
  assign full      = (fill == FW'(DEPTH));
  assign oldest_p  = full ? win_p[wr_ptr] : '0;
  assign oldest_h  = full ? win_h[wr_ptr] : '0;
  assign lo_bound  = (avg_p >= thresh) ? (avg_p - thresh) : '0;
  assign hi_bound  = {1'b0, avg_p} + {1'b0, thresh};
  assign in_range  = (cnt >= lo_bound) && ({1'b0, cnt} <= hi_bound);
  assign at_target = (stable_cnt == SCW'(STABLE_CYCLES));
  // An edge landing on the saturation cycle counts as a fresh first edge.
  assign push      = rst_n && enable && rise && armed && (cnt != CNT_MAX);

  // Deglitch: accept a new level only after it has held DEBOUNCE clocks;
  // keeps tracking through a soft clear so no false edge follows enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt   <= 1'b0;
      db_cnt <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (signal_in != filt) begin
        if (db_cnt == DBW'(DEBOUNCE - 1)) begin
          filt   <= signal_in;
          db_cnt <= '0;
          rise   <= signal_in;
          fall   <= ~signal_in;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Sample windows; stale contents are masked by fill, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      win_p[wr_ptr] <= cnt;
      win_h[wr_ptr] <= h_cap;
    end
  end

  // Measurement, averaging, stability tracking and timeout.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      cnt          <= '0;
      armed        <= 1'b0;
      h_cap        <= '0;
      wr_ptr       <= '0;
      fill         <= '0;
      sum_p        <= '0;
      sum_h        <= '0;
      stable_cnt   <= '0;
      avg_p        <= '0;
      thresh       <= '0;
      upd          <= 1'b0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      stable       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      upd          <= 1'b0;
      period_valid <= 1'b0;

      if (upd) begin
        avg_p  <= COUNTER_WIDTH'(sum_p >> AVG_LOG2);
        thresh <= COUNTER_WIDTH'(sum_p >> (AVG_LOG2 + THRESH_SHIFT));
        stable <= at_target;
        if (at_target) begin
          period       <= COUNTER_WIDTH'(sum_p >> AVG_LOG2);
          high_time    <= COUNTER_WIDTH'(sum_h >> AVG_LOG2);
          period_valid <= 1'b1;
        end else begin
          period    <= '0;
          high_time <= '0;
        end
      end

      if (fall) begin
        h_cap <= cnt;
      end

      if (rise) begin
        cnt     <= CNT_ONE;
        armed   <= 1'b1;
        timeout <= 1'b0;
        if (push) begin
          sum_p  <= sum_p + SW'(cnt) - SW'(oldest_p);
          sum_h  <= sum_h + SW'(h_cap) - SW'(oldest_h);
          wr_ptr <= wr_ptr + 1'b1;
          upd    <= 1'b1;
          if (!full) begin
            fill <= fill + 1'b1;
          end else if (!in_range) begin
            stable_cnt <= '0;
          end else if (!at_target) begin
            stable_cnt <= stable_cnt + 1'b1;
          end
        end else if (armed) begin
          fill         <= '0;
          wr_ptr       <= '0;
          sum_p        <= '0;
          sum_h        <= '0;
          stable_cnt   <= '0;
          stable       <= 1'b0;
          period       <= '0;
          high_time    <= '0;
          period_valid <= 1'b0;
        end
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end else if (armed) begin
        armed        <= 1'b0;
        timeout      <= 1'b1;
        fill         <= '0;
        wr_ptr       <= '0;
        sum_p        <= '0;
        sum_h        <= '0;
        stable_cnt   <= '0;
        stable       <= 1'b0;
        period       <= '0;
        high_time    <= '0;
        period_valid <= 1'b0;
      end
    end
  end

endmodule
